// File: rtl/codemem_loader_if.sv
// Handshake/bus bundle between a register-slice host and codemem_loader.
// master drives slices and control; slave is the loader.
interface codemem_loader_if #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int WORD_WIDTH      = 32,
  parameter int NUM_WORDS       = 2
);
  localparam int CDW = WORD_WIDTH * NUM_WORDS;

  logic [CDW-1:0]             word_value;
  logic [NUM_WORDS-1:0]       word_strobe;
  logic [CODE_ADDR_WIDTH-1:0] addr_value;
  logic                       addr_strobe;
  logic                       control_start;
  logic                       err_clear;
  logic [CODE_ADDR_WIDTH-1:0] code_mem_wr_addr;
  logic [CDW-1:0]             code_mem_wr_data;
  logic                       code_mem_wr_en;
  logic [CODE_ADDR_WIDTH:0]   inst_count;
  logic                       full;
  logic                       err_dup;
  logic                       err_overflow;

  modport master (
    output word_value, word_strobe, addr_value, addr_strobe,
    output control_start, err_clear,
    input  code_mem_wr_addr, code_mem_wr_data, code_mem_wr_en,
    input  inst_count, full, err_dup, err_overflow
  );

  modport slave (
    input  word_value, word_strobe, addr_value, addr_strobe,
    input  control_start, err_clear,
    output code_mem_wr_addr, code_mem_wr_data, code_mem_wr_en,
    output inst_count, full, err_dup, err_overflow
  );
endinterface

// File: rtl/codemem_loader.sv
// Assembles multi-slice instructions from strobed register writes
// and emits one registered code-memory write per instruction.
module codemem_loader #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int WORD_WIDTH      = 32,
  parameter int NUM_WORDS       = 2
) (
  input  logic             clk,
  input  logic             rst,
  codemem_loader_if.slave  bus
);
  localparam int CAW = CODE_ADDR_WIDTH;
  localparam int WW  = WORD_WIDTH;
  localparam int CDW = WORD_WIDTH * NUM_WORDS;

  typedef enum logic [1:0] {
    LOADING = 2'd0,
    FULL    = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_WORDS-1:0] r_mask;
  logic [NUM_WORDS-1:0] w_mask_nxt;
  logic [CDW-1:0]       r_hold;
  logic [CDW-1:0]       w_asm;
  logic [CAW-1:0]       r_ptr;
  logic [CAW-1:0]       w_ptr_nxt;
  logic [CAW:0]         r_cnt;
  logic [CAW:0]         w_cnt_nxt;
  logic                 r_wr_en;
  logic                 w_wr_en_nxt;
  logic [CAW-1:0]       r_wr_addr;
  logic [CAW-1:0]       w_wr_addr_nxt;
  logic [CDW-1:0]       r_wr_data;
  logic [CDW-1:0]       w_wr_data_nxt;
  logic                 r_dup;
  logic                 w_dup_nxt;
  logic                 r_ovf;
  logic                 w_ovf_nxt;
  logic                 w_full;
  logic                 w_done;
  logic                 w_dup_set;
  logic                 w_ovf_set;

  assign w_full = (r_state == FULL);

  // Merge held slices with slices strobed this cycle.
  always_comb begin
    w_asm = r_hold;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (bus.word_strobe[i]) begin
        w_asm[i*WW +: WW] = bus.word_value[i*WW +: WW];
      end
    end
  end

  // Completion detect, next-state and next-register values.
  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_dup_nxt     = r_dup;
    w_ovf_nxt     = r_ovf;
    w_done        = 1'b0;
    w_dup_set     = 1'b0;
    w_ovf_set     = 1'b0;
    if (bus.control_start) begin
      w_state_nxt = HALT;
      w_mask_nxt  = '0;
      w_ptr_nxt   = '0;
      w_cnt_nxt   = '0;
      w_dup_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else begin
      w_done     = &(r_mask | bus.word_strobe);
      w_mask_nxt = w_done ? '0 : (r_mask | bus.word_strobe);
      w_dup_set  = (|(r_mask & bus.word_strobe)) && !w_done;
      w_ovf_set  = w_done && w_full;
      if (w_done && !w_full) begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_ptr;
        w_wr_data_nxt = w_asm;
        w_ptr_nxt     = r_ptr + 1'b1;
        w_cnt_nxt     = r_cnt + 1'b1;
      end
      // An explicit pointer load overrides the post-write increment.
      if (bus.addr_strobe) begin
        w_ptr_nxt = bus.addr_value;
      end
      w_dup_nxt = w_dup_set | (r_dup & ~bus.err_clear);
      w_ovf_nxt = w_ovf_set | (r_ovf & ~bus.err_clear);
      if (bus.addr_strobe) begin
        w_state_nxt = LOADING;
      end else if (w_done && !w_full && (r_ptr == '1)) begin
        w_state_nxt = FULL;
      end else if (r_state == HALT) begin
        w_state_nxt = LOADING;
      end
    end
  end

  // State, pointer, counters and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOADING;
      r_mask    <= '0;
      r_hold    <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_dup     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_hold    <= w_asm;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_dup     <= w_dup_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign bus.code_mem_wr_en   = r_wr_en;
  assign bus.code_mem_wr_addr = r_wr_addr;
  assign bus.code_mem_wr_data = r_wr_data;
  assign bus.inst_count       = r_cnt;
  assign bus.full             = w_full;
  assign bus.err_dup          = r_dup;
  assign bus.err_overflow     = r_ovf;
endmodule
